// File: rtl/mem_access_if.sv
// Bus bundle between the pipeline MEM stage, the ram block and serial status for mem_access.
// Shared RAM op/enable encodings are defined here so both sides agree on them.
`ifndef RAM_OP_RD
`define RAM_OP_RD 1'b0
`endif
`ifndef RAM_OP_WR
`define RAM_OP_WR 1'b1
`endif
`ifndef RAM_ENABLE
`define RAM_ENABLE 1'b1
`endif

interface mem_access_if;
  logic        req_rd;
  logic        req_wr;
  logic [17:0] req_addr;
  logic [15:0] req_data;
  logic [17:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_op;
  logic        ram_en;
  logic [15:0] ram_rdata;
  logic        ram_pause;
  logic        tsre;
  logic        tbre;
  logic        data_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        stall;
  logic        timeout;

  modport master (
    output req_rd, req_wr, req_addr, req_data, ram_rdata, ram_pause, tsre, tbre, data_ready,
    input  ram_addr, ram_wdata, ram_op, ram_en, rd_data, rd_valid, stall, timeout
  );

  modport slave (
    input  req_rd, req_wr, req_addr, req_data, ram_rdata, ram_pause, tsre, tbre, data_ready,
    output ram_addr, ram_wdata, ram_op, ram_en, rd_data, rd_valid, stall, timeout
  );
endinterface

// File: rtl/mem_access.sv
// MEM-stage load/store sequencer: one-cycle ram access per request, optional serial-port wait.
// Optional feature macro: MEM_SERIAL_WAIT_EN (SWAIT state, wait counter, timeout for 18'hBF00).
`ifndef RAM_OP_RD
`define RAM_OP_RD 1'b0
`endif
`ifndef RAM_OP_WR
`define RAM_OP_WR 1'b1
`endif
`ifndef RAM_ENABLE
`define RAM_ENABLE 1'b1
`endif

module mem_access #(
  parameter logic [15:0] WAIT_LIMIT = 16'd50000
) (
  input  logic         clk_50MHz,
  input  logic         rst,
  mem_access_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, SWAIT, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [17:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_op;
  logic        r_en;
  logic [15:0] r_rd_data;
  logic        r_rd_valid;
  logic        w_accept;
  logic        w_req_op;
  logic        w_wait_expired;

`ifdef MEM_SERIAL_WAIT_EN
  localparam logic [17:0] SERIAL_ADDR = 18'hBF00;
  logic [15:0] r_wait_cnt;
  logic        r_timeout;
  logic        w_serial_ok;
`endif

  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    w_wait_expired = 1'b0;
    w_req_op       = bus.req_wr ? `RAM_OP_WR : `RAM_OP_RD;
`ifdef MEM_SERIAL_WAIT_EN
    w_serial_ok    = (r_op == `RAM_OP_RD) ? bus.data_ready : (bus.tsre && bus.tbre);
`endif
    case (r_state)
      IDLE: begin
        if (bus.req_rd || bus.req_wr) begin
          w_accept = 1'b1;
          w_next   = ACCESS;
`ifdef MEM_SERIAL_WAIT_EN
          if (bus.req_addr == SERIAL_ADDR) w_next = SWAIT;
`endif
        end
      end
      ACCESS: w_next = DONE;
`ifdef MEM_SERIAL_WAIT_EN
      SWAIT: begin
        if (w_serial_ok) begin
          w_next = ACCESS;
        end else if (r_wait_cnt == WAIT_LIMIT - 16'd1) begin
          w_next         = DONE;
          w_wait_expired = 1'b1;
        end
      end
`endif
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ram_en and rd_valid are registered from the next state so they track ACCESS/DONE exactly.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_op       <= `RAM_OP_RD;
      r_en       <= ~`RAM_ENABLE;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_en       <= (w_next == ACCESS) ? `RAM_ENABLE : ~`RAM_ENABLE;
      r_rd_valid <= (w_next == DONE) && (r_op == `RAM_OP_RD);
      if (w_accept) begin
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_data;
        r_op    <= w_req_op;
      end
      if (r_state == ACCESS && r_op == `RAM_OP_RD) r_rd_data <= bus.ram_rdata;
      else if (w_wait_expired)                     r_rd_data <= '0;
    end
  end

`ifdef MEM_SERIAL_WAIT_EN
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_accept) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (r_state == SWAIT) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
      if (w_wait_expired) r_timeout <= 1'b1;
    end
  end

  assign bus.timeout = r_timeout;
`else
  logic w_unused_serial;
  assign w_unused_serial = ^{WAIT_LIMIT, bus.tsre, bus.tbre, bus.data_ready};
  assign bus.timeout     = 1'b0;
`endif

  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.ram_op    = r_op;
  assign bus.ram_en    = r_en;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  // DONE releases the pipeline; ram_pause only matters while the access is on the bus.
  assign bus.stall = (r_state == IDLE) ? (bus.req_rd | bus.req_wr)
                                       : ((r_state != DONE) | ((r_state == ACCESS) & bus.ram_pause));
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: read data scoreboard plus per-cycle control checks.
`ifndef RAM_OP_RD
`define RAM_OP_RD 1'b0
`endif
`ifndef RAM_OP_WR
`define RAM_OP_WR 1'b1
`endif

module tb_mem_access;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_checks  = 0;
  int unsigned n_fail    = 0;
  int unsigned en_cycles = 0;
  logic [15:0] exp_q[$];

  mem_access_if bus();

  mem_access #(.WAIT_LIMIT(16'd8)) dut (
    .clk_50MHz (clk),
    .rst       (rst_n),
    .bus       (bus)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.ram_en === 1'b1) en_cycles++;
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("rd_valid_unexpected", 32'(bus.rd_valid), 32'd0);
      else chk("rd_data_scoreboard", 32'(bus.rd_data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [17:0] a, input logic [15:0] d);
    bus.req_rd   = rd;
    bus.req_wr   = wr;
    bus.req_addr = a;
    bus.req_data = d;
    #1;
    chk("stall_on_request", 32'(bus.stall), 32'd1);
    tick();
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b0;
  endtask

  initial begin
    bus.req_rd     = 1'b0;
    bus.req_wr     = 1'b0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.ram_rdata  = '0;
    bus.ram_pause  = 1'b0;
    bus.tsre       = 1'b1;
    bus.tbre       = 1'b1;
    bus.data_ready = 1'b0;
    #3;
    chk("reset_ram_en",    32'(bus.ram_en),    32'd0);
    chk("reset_rd_valid",  32'(bus.rd_valid),  32'd0);
    chk("reset_timeout",   32'(bus.timeout),   32'd0);
    chk("reset_rd_data",   32'(bus.rd_data),   32'd0);
    chk("reset_ram_addr",  32'(bus.ram_addr),  32'd0);
    chk("reset_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("reset_ram_op",    32'(bus.ram_op),    32'(`RAM_OP_RD));
    chk("reset_stall",     32'(bus.stall),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_stall", 32'(bus.stall), 32'd0);

    // Plain read: ram_rdata changes around ACCESS so only the ACCESS-cycle value may be latched
    en_cycles = 0;
    exp_q.push_back(16'hBEEF);
    issue(1'b1, 1'b0, 18'h00100, 16'h0000);
    chk("rd_access_en",    32'(bus.ram_en),   32'd1);
    chk("rd_access_addr",  32'(bus.ram_addr), 32'h00100);
    chk("rd_access_op",    32'(bus.ram_op),   32'(`RAM_OP_RD));
    chk("rd_access_stall", 32'(bus.stall),    32'd1);
    chk("rd_valid_early",  32'(bus.rd_valid), 32'd0);
    bus.ram_rdata = 16'hBEEF;
    tick();
    bus.ram_rdata = 16'h1111;
    chk("rd_valid_latency2", 32'(bus.rd_valid), 32'd1);
    chk("rd_done_stall",     32'(bus.stall),    32'd0);
    chk("rd_done_en",        32'(bus.ram_en),   32'd0);
    tick();
    chk("rd_valid_pulse",  32'(bus.rd_valid), 32'd0);
    chk("rd_data_hold",    32'(bus.rd_data),  32'hBEEF);
    chk("rd_en_cycles",    en_cycles,         32'd1);

    // Plain write
    en_cycles = 0;
    issue(1'b0, 1'b1, 18'h09000, 16'h1234);
    chk("wr_access_op",    32'(bus.ram_op),    32'(`RAM_OP_WR));
    chk("wr_access_wdata", 32'(bus.ram_wdata), 32'h1234);
    chk("wr_access_addr",  32'(bus.ram_addr),  32'h09000);
    chk("wr_access_en",    32'(bus.ram_en),    32'd1);
    tick();
    chk("wr_no_rd_valid",  32'(bus.rd_valid),  32'd0);
    chk("wr_done_en",      32'(bus.ram_en),    32'd0);
    chk("wr_done_stall",   32'(bus.stall),     32'd0);
    tick();
    chk("hold_addr",       32'(bus.ram_addr),  32'h09000);
    chk("hold_wdata",      32'(bus.ram_wdata), 32'h1234);
    chk("wr_en_cycles",    en_cycles,          32'd1);

    // Simultaneous read and write: write wins
    en_cycles = 0;
    issue(1'b1, 1'b1, 18'h00200, 16'h5A5A);
    chk("both_op",    32'(bus.ram_op),    32'(`RAM_OP_WR));
    chk("both_wdata", 32'(bus.ram_wdata), 32'h5A5A);
    chk("both_addr",  32'(bus.ram_addr),  32'h00200);
    tick();
    chk("both_no_rd_valid", 32'(bus.rd_valid), 32'd0);
    tick();
    chk("both_en_cycles", en_cycles, 32'd1);

    // ram_pause stalls but does not stretch ACCESS, and is ignored in DONE
    exp_q.push_back(16'h7777);
    bus.ram_rdata = 16'h7777;
    issue(1'b1, 1'b0, 18'h00400, 16'h0000);
    bus.ram_pause = 1'b1;
    #1;
    chk("pause_stall_access", 32'(bus.stall), 32'd1);
    tick();
    chk("pause_not_extended", 32'(bus.ram_en),   32'd0);
    chk("pause_done_valid",   32'(bus.rd_valid), 32'd1);
    chk("pause_done_stall",   32'(bus.stall),    32'd0);
    bus.ram_pause = 1'b0;
    tick();

`ifndef MEM_SERIAL_WAIT_EN
    // Without the serial feature 18'hBF00 is an ordinary address
    exp_q.push_back(16'hCAFE);
    bus.ram_rdata = 16'hCAFE;
    issue(1'b1, 1'b0, 18'h0BF00, 16'h0000);
    chk("bf00_direct_access", 32'(bus.ram_en), 32'd1);
    tick();
    chk("bf00_timeout_tied", 32'(bus.timeout), 32'd0);
    tick();
`else
    // Serial read: data_ready appears in the 5th SWAIT cycle
    en_cycles      = 0;
    bus.data_ready = 1'b0;
    exp_q.push_back(16'hCAFE);
    bus.ram_rdata  = 16'hCAFE;
    issue(1'b1, 1'b0, 18'h0BF00, 16'h0000);
    for (int c = 1; c <= 4; c++) begin
      chk("swait_no_en", 32'(bus.ram_en), 32'd0);
      chk("swait_stall", 32'(bus.stall),  32'd1);
      tick();
    end
    chk("swait_no_en_c5", 32'(bus.ram_en), 32'd0);
    bus.data_ready = 1'b1;
    tick();
    chk("swait_then_access", 32'(bus.ram_en), 32'd1);
    bus.data_ready = 1'b0;
    tick();
    chk("swait_rd_latency7", 32'(bus.rd_valid), 32'd1);
    tick();
    chk("swait_en_cycles", en_cycles, 32'd1);

    // Serial write timeout with tsre stuck low, WAIT_LIMIT=8
    en_cycles = 0;
    bus.tsre  = 1'b0;
    issue(1'b0, 1'b1, 18'h0BF00, 16'hABCD);
    for (int c = 1; c <= 8; c++) begin
      chk("timeout_early", 32'(bus.timeout), 32'd0);
      tick();
    end
    chk("timeout_set",      32'(bus.timeout),  32'd1);
    chk("timeout_rd_data",  32'(bus.rd_data),  32'd0);
    chk("timeout_stall",    32'(bus.stall),    32'd0);
    chk("timeout_no_valid", 32'(bus.rd_valid), 32'd0);
    tick();
    chk("timeout_hold",     32'(bus.timeout),  32'd1);
    chk("timeout_no_en",    en_cycles,         32'd0);
    bus.tsre = 1'b1;
    exp_q.push_back(16'h2468);
    bus.ram_rdata = 16'h2468;
    issue(1'b1, 1'b0, 18'h00500, 16'h0000);
    chk("timeout_cleared", 32'(bus.timeout), 32'd0);
    tick();
    tick();
`endif

    // Reset in the middle of ACCESS discards the request
    bus.ram_rdata = 16'h9999;
    issue(1'b1, 1'b0, 18'h00300, 16'h0000);
    chk("rst_pre_en", 32'(bus.ram_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_en_async",  32'(bus.ram_en),   32'd0);
    chk("rst_idle_stall", 32'(bus.stall),   32'd0);
    chk("rst_addr_clear", 32'(bus.ram_addr), 32'd0);
    chk("rst_rd_data",    32'(bus.rd_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_no_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 16'd50000, meaning maximum serial-wait cycles before timeout.
REQ-002 SHALL have port clk_50MHz  input  1  system clock 50 MHz; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req_rd, req_wr  input  1 each  load/store request from the EX/MEM register.
REQ-005 SHALL have ports req_addr  input  18  and req_data  input  16  access address and store data.
REQ-006 SHALL have ports ram_addr  output  18, ram_wdata  output  16, ram_op  output  1, ram_en  output  1  driving the ram block's addr, data_i, op and en.
REQ-007 SHALL have ports ram_rdata  input  16  and ram_pause  input  1  taken from the ram block's data_o and ram_pause.
REQ-008 SHALL have ports tsre, tbre, data_ready  input  1 each  serial status.
REQ-009 SHALL have ports rd_data  output  16, rd_valid  output  1, stall  output  1, timeout  output  1  toward the pipeline.

Function
REQ-010 SHALL implement states IDLE, ACCESS, SWAIT, DONE.
REQ-011 In IDLE with req_wr=1, SHALL capture req_addr/req_data, set op to `RAM_OP_WR and go to ACCESS; with only req_rd=1, SHALL capture and set `RAM_OP_RD; with both set, the write wins and the read is dropped.
REQ-012 If the captured address is 18'hBF00 and MEM_SERIAL_WAIT_EN is defined, SHALL go to SWAIT instead of ACCESS.
REQ-013 In SWAIT, SHALL increment a 16-bit wait counter each cycle; when data_ready=1 (read) or tsre&&tbre=1 (write), SHALL go to ACCESS.
REQ-014 In SWAIT, when the counter reaches WAIT_LIMIT-1 without the condition, SHALL go to DONE with timeout=1 and rd_data=16'h0000, and SHALL never assert ram_en.
REQ-015 In ACCESS, SHALL drive ram_en=`RAM_ENABLE for exactly one cycle, with ram_addr/ram_wdata/ram_op held from the capture; ram_en SHALL be inactive in every other state.
REQ-016 ACCESS -> DONE SHALL be unconditional; for reads, rd_data SHALL latch ram_rdata at the end of the ACCESS cycle.
REQ-017 In DONE, SHALL pulse rd_valid=1 for one cycle on reads only and return to IDLE; timeout SHALL hold until the next accepted request.
REQ-018 stall SHALL be combinational: 1 when state≠IDLE, or when in IDLE with req_rd|req_wr=1; it SHALL be 0 in DONE so the pipeline advances.
REQ-019 ram_pause=1 during ACCESS SHALL be OR-ed into stall but SHALL NOT extend ACCESS.
REQ-020 Read latency SHALL be 2 cycles from request acceptance to rd_valid on a non-serial path; writes SHALL complete in 2 cycles.
REQ-021 ram_addr/ram_wdata SHALL hold their last captured value outside ACCESS.

Reset
REQ-022 On rst=0, SHALL immediately enter IDLE and clear ram_en, rd_valid, timeout, rd_data, ram_addr, ram_wdata, and the wait counter to 0, and set ram_op=`RAM_OP_RD.
REQ-023 A reset mid-ACCESS SHALL deassert ram_en asynchronously; the interrupted request SHALL be discarded.

Configuration
REQ-024 Macro MEM_SERIAL_WAIT_EN: when defined, SWAIT, the wait counter and timeout logic SHALL be compiled in; when undefined, 18'hBF00 accesses SHALL take the ACCESS path like any other address, and timeout SHALL be tied to 0.

Verification
REQ-025 Read 18'h0100 with ram_rdata=16'hBEEF -> ram_en high for 1 cycle, rd_valid with rd_data=16'hBEEF 2 cycles after accept, stall high 2 cycles.
REQ-026 Write 18'h9000 with data 16'h1234 -> ram_op=`RAM_OP_WR, ram_wdata=16'h1234 for one ACCESS cycle, no rd_valid.
REQ-027 Macro on, read 18'hBF00 with data_ready rising after 5 cycles -> ACCESS follows, rd_valid 7 cycles after accept.
REQ-028 Macro on, WAIT_LIMIT=8, write 18'hBF00 with tsre=0 -> timeout=1 after 8 SWAIT cycles, no ram_en pulse.
REQ-029 req_rd=req_wr=1 at 18'h0200 -> a single write access only; rst pulsed during ACCESS -> ram_en low at once, state IDLE.
